// File: rtl/cnt_mon_pkg.sv
// ============================================================================
// Module   : cnt_mon_pkg
// Brief    : Shared types for the counter wrap monitor (FSM states, event kinds)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_mon_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } mon_state_e;

  // Kinds of event presented through the slot
  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_WRAP_UP = 2'd1,
    EVT_WRAP_DN = 2'd2,
    EVT_JUMP    = 2'd3
  } evt_kind_e;

endpackage : cnt_mon_pkg

`default_nettype wire

// File: rtl/cnt_evt_slot.sv
// ============================================================================
// Module   : cnt_evt_slot
// Brief    : One-entry valid/ack event holding register with sticky overflow.
//            A new event is accepted when the slot is empty or being acked in
//            the same cycle; otherwise it is dropped and overflow is flagged.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_evt_slot
  import cnt_mon_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_clr,
  input  logic      i_evt,
  input  evt_kind_e i_kind,
  input  logic      i_ack,
  output logic      o_valid,
  output evt_kind_e o_kind,
  output logic      o_ovf
);

  logic      r_valid;
  evt_kind_e r_kind;
  logic      r_ovf;

  // Slot occupancy, held kind and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_kind  <= EVT_NONE;
      r_ovf   <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_kind  <= EVT_NONE;
      r_ovf   <= 1'b0;
    end else if (i_evt) begin
      if (!r_valid || i_ack) begin
        r_valid <= 1'b1;
        r_kind  <= i_kind;
      end else begin
        r_ovf   <= 1'b1;
      end
    end else if (r_valid && i_ack) begin
      r_valid <= 1'b0;
      r_kind  <= EVT_NONE;
    end
  end

  assign o_valid = r_valid;
  assign o_kind  = r_kind;
  assign o_ovf   = r_ovf;

endmodule : cnt_evt_slot

`default_nettype wire

// File: rtl/cnt_wrap_monitor.sv
// ============================================================================
// Module   : cnt_wrap_monitor
// Brief    : Watches a CNT_W-bit up/down counter, reports wrap-arounds and
//            illegal jumps through a one-entry valid/ack slot and keeps a
//            saturating wrap tally.
//            Optional feature macro: CNT_MON_HIST_EN (min/max count history).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_wrap_monitor
  import cnt_mon_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int WRAPS_W = 8
) (
  input  logic               cnt_clk,
  input  logic               cnt_rst,
  input  logic               mon_clr,
  input  logic               cnt_dir,
  input  logic [CNT_W-1:0]   count_in,
  input  logic               evt_ack,
  output logic               evt_valid,
  output logic [1:0]         evt_kind,
  output logic               evt_ovf,
  output logic [WRAPS_W-1:0] wrap_cnt,
  output logic               err,
  output logic [CNT_W-1:0]   min_seen,
  output logic [CNT_W-1:0]   max_seen
);

  localparam logic [CNT_W-1:0]   c_cnt_max  = '1;
  localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);
  localparam logic [WRAPS_W-1:0] c_wrap_max = '1;
  localparam logic [WRAPS_W-1:0] c_wrap_one = WRAPS_W'(1);

  mon_state_e         r_state;
  logic [CNT_W-1:0]   r_prev;
  logic [WRAPS_W-1:0] r_wrap;
  logic               r_err;

  logic [CNT_W-1:0]   w_d;
  logic               w_track;
  logic               w_wrap_up;
  logic               w_wrap_dn;
  logic               w_legal;
  logic               w_jump;
  logic               w_evt;
  evt_kind_e          w_kind;
  evt_kind_e          w_slot_kind;

  // Step classification; a wrap whose direction disagrees is still a legal +/-1 step
  assign w_d       = count_in - r_prev;
  assign w_track   = (r_state == S_TRACK);
  assign w_legal   = (w_d == '0) || (w_d == c_cnt_one) || (w_d == c_cnt_max);
  assign w_wrap_up = w_track && (r_prev == c_cnt_max) && (count_in == '0) && cnt_dir;
  assign w_wrap_dn = w_track && (r_prev == '0) && (count_in == c_cnt_max) && !cnt_dir;
  assign w_jump    = w_track && !w_legal;
  assign w_evt     = w_wrap_up || w_wrap_dn || w_jump;

  // Encode the kind of the event detected this cycle
  always_comb begin
    w_kind = EVT_NONE;
    if (w_wrap_up)      w_kind = EVT_WRAP_UP;
    else if (w_wrap_dn) w_kind = EVT_WRAP_DN;
    else if (w_jump)    w_kind = EVT_JUMP;
  end

  // Monitor FSM: previous-sample tracking, fault latch and saturating wrap tally
  always_ff @(posedge cnt_clk or posedge cnt_rst) begin
    if (cnt_rst) begin
      r_state <= S_INIT;
      r_prev  <= '0;
      r_wrap  <= '0;
      r_err   <= 1'b0;
    end else if (mon_clr) begin
      r_state <= S_INIT;
      r_prev  <= '0;
      r_wrap  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_prev  <= count_in;
          r_state <= S_TRACK;
        end
        S_TRACK: begin
          r_prev <= count_in;
          if (w_jump) begin
            r_state <= S_FAULT;
            r_err   <= 1'b1;
          end
          if ((w_wrap_up || w_wrap_dn) && (r_wrap != c_wrap_max)) begin
            r_wrap <= r_wrap + c_wrap_one;
          end
        end
        S_FAULT: begin
          r_prev <= count_in;
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

  cnt_evt_slot u_slot (
    .clk     (cnt_clk),
    .rst     (cnt_rst),
    .i_clr   (mon_clr),
    .i_evt   (w_evt),
    .i_kind  (w_kind),
    .i_ack   (evt_ack),
    .o_valid (evt_valid),
    .o_kind  (w_slot_kind),
    .o_ovf   (evt_ovf)
  );

  assign evt_kind = w_slot_kind;
  assign wrap_cnt = r_wrap;
  assign err      = r_err;

`ifdef CNT_MON_HIST_EN
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;

  // Running min/max of the sampled count; the first sample seeds both
  always_ff @(posedge cnt_clk or posedge cnt_rst) begin
    if (cnt_rst) begin
      r_min <= c_cnt_max;
      r_max <= '0;
    end else if (mon_clr) begin
      r_min <= c_cnt_max;
      r_max <= '0;
    end else if (r_state == S_INIT) begin
      r_min <= count_in;
      r_max <= count_in;
    end else begin
      if (count_in < r_min) r_min <= count_in;
      if (count_in > r_max) r_max <= count_in;
    end
  end

  assign min_seen = r_min;
  assign max_seen = r_max;
`else
  assign min_seen = '0;
  assign max_seen = '0;
`endif

endmodule : cnt_wrap_monitor

`default_nettype wire

// File: tb/tb_cnt_wrap_monitor.sv
// ============================================================================
// Module   : tb_cnt_wrap_monitor
// Brief    : Directed self-checking bench for cnt_wrap_monitor
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_wrap_monitor;

  logic       clk;
  logic       rst;
  logic       mon_clr;
  logic       cnt_dir;
  logic [3:0] count_in;
  logic       evt_ack;
  logic       evt_valid;
  logic [1:0] evt_kind;
  logic       evt_ovf;
  logic [7:0] wrap_cnt;
  logic       err;
  logic [3:0] min_seen;
  logic [3:0] max_seen;

  int n_checks = 0;
  int n_fail   = 0;

  cnt_wrap_monitor #(.CNT_W(4), .WRAPS_W(8)) dut (
    .cnt_clk   (clk),
    .cnt_rst   (rst),
    .mon_clr   (mon_clr),
    .cnt_dir   (cnt_dir),
    .count_in  (count_in),
    .evt_ack   (evt_ack),
    .evt_valid (evt_valid),
    .evt_kind  (evt_kind),
    .evt_ovf   (evt_ovf),
    .wrap_cnt  (wrap_cnt),
    .err       (err),
    .min_seen  (min_seen),
    .max_seen  (max_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_min;
    logic [3:0] exp_max;
`ifdef CNT_MON_HIST_EN
    exp_min = 4'hF;
    exp_max = 4'h0;
`else
    exp_min = 4'h0;
    exp_max = 4'h0;
`endif
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d expected 0", evt_valid); end
    n_checks++; if (evt_kind !== 2'd0) begin n_fail++; $display("FAIL reset_kind: got %0d expected 0", evt_kind); end
    n_checks++; if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0d expected 0", evt_ovf); end
    n_checks++; if (wrap_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_wrap: got %0d expected 0", wrap_cnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err); end
    n_checks++; if (min_seen !== exp_min) begin n_fail++; $display("FAIL reset_min: got %0d expected %0d", min_seen, exp_min); end
    n_checks++; if (max_seen !== exp_max) begin n_fail++; $display("FAIL reset_max: got %0d expected %0d", max_seen, exp_max); end
  endtask

  task automatic test_wrap_up();
    int n_ev;
    do_clear();
    cnt_dir  = 1'b1;
    count_in = 4'd0;
    step();
    n_ev = 0;
    for (int v = 1; v < 16; v++) begin
      count_in = 4'(v);
      step();
      if (evt_valid) n_ev++;
    end
    n_checks++; if (n_ev !== 0) begin n_fail++; $display("FAIL up_no_early_evt: got %0d expected 0", n_ev); end
    count_in = 4'd0;
    step();
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL up_valid: got %0d expected 1", evt_valid); end
    n_checks++; if (evt_kind !== 2'd1) begin n_fail++; $display("FAIL up_kind: got %0d expected 1", evt_kind); end
    n_checks++; if (wrap_cnt !== 8'd1) begin n_fail++; $display("FAIL up_wrap: got %0d expected 1", wrap_cnt); end
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL up_ack_clears: got %0d expected 0", evt_valid); end
  endtask

  task automatic test_wrap_dn();
    cnt_dir  = 1'b0;
    count_in = 4'd15;
    step();
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL dn_valid: got %0d expected 1", evt_valid); end
    n_checks++; if (evt_kind !== 2'd2) begin n_fail++; $display("FAIL dn_kind: got %0d expected 2", evt_kind); end
    n_checks++; if (wrap_cnt !== 8'd2) begin n_fail++; $display("FAIL dn_wrap: got %0d expected 2", wrap_cnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL dn_err: got %0d expected 0", err); end
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    // 15 -> 0 while direction says down: legal, silent
    count_in = 4'd0;
    step();
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL disagree_valid: got %0d expected 0", evt_valid); end
    n_checks++; if (wrap_cnt !== 8'd2) begin n_fail++; $display("FAIL disagree_wrap: got %0d expected 2", wrap_cnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL disagree_err: got %0d expected 0", err); end
  endtask

  task automatic test_jump();
    do_clear();
    cnt_dir  = 1'b1;
    count_in = 4'd3;
    step();
    count_in = 4'd9;
    step();
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL jump_valid: got %0d expected 1", evt_valid); end
    n_checks++; if (evt_kind !== 2'd3) begin n_fail++; $display("FAIL jump_kind: got %0d expected 3", evt_kind); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL jump_err: got %0d expected 1", err); end
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    count_in = 4'd15;
    step();
    count_in = 4'd0;
    step();
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL fault_no_evt: got %0d expected 0", evt_valid); end
    n_checks++; if (wrap_cnt !== 8'd0) begin n_fail++; $display("FAIL fault_no_tally: got %0d expected 0", wrap_cnt); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL fault_err_held: got %0d expected 1", err); end
    do_clear();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %0d expected 0", err); end
    // First sample after clear only seeds prev, so 0 -> 7 is not a jump
    count_in = 4'd7;
    step();
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL clr_init_valid: got %0d expected 0", evt_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL clr_init_err: got %0d expected 0", err); end
  endtask

  task automatic test_overflow();
    do_clear();
    cnt_dir  = 1'b1;
    count_in = 4'd15;
    step();
    count_in = 4'd0;
    step();
    n_checks++; if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_first: got %0d expected 0", evt_ovf); end
    for (int i = 0; i < 15; i++) step();
    cnt_dir  = 1'b0;
    count_in = 4'd15;
    step();
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %0d expected 1", evt_valid); end
    n_checks++; if (evt_kind !== 2'd1) begin n_fail++; $display("FAIL ovf_kind_kept: got %0d expected 1", evt_kind); end
    n_checks++; if (evt_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0d expected 1", evt_ovf); end
    n_checks++; if (wrap_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_wrap: got %0d expected 2", wrap_cnt); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    cnt_dir  = 1'b1;
    count_in = 4'd15;
    step();
    count_in = 4'd0;
    step();
    cnt_dir  = 1'b0;
    count_in = 4'd15;
    evt_ack  = 1'b1;
    step();
    evt_ack  = 1'b0;
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %0d expected 1", evt_valid); end
    n_checks++; if (evt_kind !== 2'd2) begin n_fail++; $display("FAIL b2b_kind: got %0d expected 2", evt_kind); end
    n_checks++; if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %0d expected 0", evt_ovf); end
    n_checks++; if (wrap_cnt !== 8'd2) begin n_fail++; $display("FAIL b2b_wrap: got %0d expected 2", wrap_cnt); end
  endtask

  task automatic test_saturate();
    do_clear();
    cnt_dir  = 1'b1;
    count_in = 4'd0;
    step();
    for (int w = 0; w < 300; w++) begin
      for (int v = 1; v < 16; v++) begin
        count_in = 4'(v);
        step();
      end
      count_in = 4'd0;
      step();
    end
    n_checks++; if (wrap_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_wrap: got %0d expected 255", wrap_cnt); end
    n_checks++; if (evt_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %0d expected 1", evt_ovf); end
    // Asynchronous reset between edges
    rst = 1'b1;
    #2;
    n_checks++; if (wrap_cnt !== 8'd0) begin n_fail++; $display("FAIL async_wrap: got %0d expected 0", wrap_cnt); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %0d expected 0", evt_valid); end
    n_checks++; if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL async_ovf: got %0d expected 0", evt_ovf); end
    n_checks++; if (evt_kind !== 2'd0) begin n_fail++; $display("FAIL async_kind: got %0d expected 0", evt_kind); end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_hist();
    logic [3:0] seq [6];
    logic [3:0] exp_min;
    logic [3:0] exp_max;
    seq[0] = 4'd5; seq[1] = 4'd6; seq[2] = 4'd7;
    seq[3] = 4'd6; seq[4] = 4'd5; seq[5] = 4'd4;
`ifdef CNT_MON_HIST_EN
    exp_min = 4'd4;
    exp_max = 4'd7;
`else
    exp_min = 4'd0;
    exp_max = 4'd0;
`endif
    do_clear();
    cnt_dir = 1'b1;
    for (int i = 0; i < 6; i++) begin
      count_in = seq[i];
      step();
    end
    n_checks++; if (min_seen !== exp_min) begin n_fail++; $display("FAIL hist_min: got %0d expected %0d", min_seen, exp_min); end
    n_checks++; if (max_seen !== exp_max) begin n_fail++; $display("FAIL hist_max: got %0d expected %0d", max_seen, exp_max); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL hist_err: got %0d expected 0", err); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL hist_valid: got %0d expected 0", evt_valid); end
  endtask

  initial begin
    rst      = 1'b1;
    mon_clr  = 1'b0;
    cnt_dir  = 1'b1;
    count_in = 4'd0;
    evt_ack  = 1'b0;
    test_reset();
    test_wrap_up();
    test_wrap_dn();
    test_jump();
    test_overflow();
    test_back_to_back();
    test_saturate();
    test_hist();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cnt_wrap_monitor

`default_nettype wire
